nand_bist: RTL and testbench

Built-in stimulus/checker for the registered 8-bit NAND datapath block: drives pseudo-random operand pairs into its `a`/`b` inputs and sequences its reset. Samples its `out` after a fixed latency, compares against bitwise `~(a & b)`, and accumulates pass/fail counts. Sits beside the NAND block at the top level so the same vector-and-check flow runs in hardware, not only in simulation.

---
 rtl/nand_bist_pkg.sv | 23 ++
 rtl/lfsr16.sv | 24 ++
 rtl/nand_bist.sv | 131 +++++++++++++
 tb/tb_nand_bist.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/nand_bist_pkg.sv
// nand_bist shared types and constants.
// State enum, LFSR taps/seed, DUT reset length, LFSR step helper.
package nand_bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DUT_RST,
    RUN,
    DONE
  } state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] DEF_SEED  = 16'hACE1;
  localparam int          RST_CYC   = 2;

  // Right-shifting Galois step, x^16+x^14+x^13+x^11+1
  function automatic logic [15:0] lfsr_step(
    input logic [15:0] s
  );
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR holding the BIST operand state.
// Ports: clk, reset (sync low), load/seed, advance, state.
module lfsr16
  import nand_bist_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        advance,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= seed;
    end else if (load) begin
      state <= seed;
    end else if (advance) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/nand_bist.sv
// BIST stimulus/checker for the registered 8-bit NAND block.
// Ports: clk, reset, start, dut_out in; dut_rst_n, a, b, busy, done, pass_cnt, fail_cnt out.
module nand_bist
  import nand_bist_pkg::*;
#(
  parameter int          NUM_VECTORS = 1000,
  parameter int          LATENCY     = 1,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       dut_out,
  output logic             dut_rst_n,
  output logic [7:0]       a,
  output logic [7:0]       b,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  localparam logic [15:0] SEED_EFF =
    (SEED == 16'h0) ? DEF_SEED : SEED;
  localparam int VW =
    (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
  localparam int WW = $clog2(LATENCY + 1);
  localparam int RW =
    (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  state_t          st;
  logic [VW-1:0]   vcnt;
  logic [WW-1:0]   wcnt;
  logic [RW-1:0]   rcnt;
  logic [15:0]     lfsr_q;
  logic [15:0]     nxt;
  logic            lfsr_ld;
  logic            lfsr_adv;
  logic            cmp;
  logic            last;
  logic            match;
  logic            go;

  assign go       = start && (st == IDLE || st == DONE);
  assign cmp      = (st == RUN) && (wcnt == WW'(LATENCY));
  assign last     = vcnt == VW'(NUM_VECTORS - 1);
  assign lfsr_ld  = go;
  assign lfsr_adv = cmp && !last;
  assign nxt      = lfsr_step(lfsr_q);
  // X/Z on dut_out makes this non-true, so it lands on fail
  assign match    = (dut_out == ~(a & b));

  lfsr16 u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (lfsr_ld),
    .seed    (SEED_EFF),
    .advance (lfsr_adv),
    .state   (lfsr_q)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      st        <= IDLE;
      a         <= '0;
      b         <= '0;
      dut_rst_n <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      vcnt      <= '0;
      wcnt      <= '0;
      rcnt      <= '0;
    end else begin
      unique case (st)
        IDLE, DONE: begin
          if (st == IDLE) dut_rst_n <= 1'b1;
          if (start) begin
            st        <= DUT_RST;
            dut_rst_n <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            vcnt      <= '0;
            wcnt      <= '0;
            rcnt      <= '0;
          end
        end
        DUT_RST: begin
          if (rcnt == RW'(RST_CYC - 1)) begin
            st        <= RUN;
            dut_rst_n <= 1'b1;
            a         <= lfsr_q[7:0];
            b         <= lfsr_q[15:8];
            wcnt      <= '0;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        RUN: begin
          if (cmp) begin
            if (match) begin
              if (pass_cnt != '1)
                pass_cnt <= pass_cnt + 1'b1;
            end else begin
              if (fail_cnt != '1)
                fail_cnt <= fail_cnt + 1'b1;
            end
            if (last) begin
              st   <= DONE;
              busy <= 1'b0;
              done <= 1'b1;
            end else begin
              vcnt <= vcnt + 1'b1;
              wcnt <= '0;
              a    <= nxt[7:0];
              b    <= nxt[15:8];
            end
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nand_bist.sv
// Self-checking bench for nand_bist.
// Five checker instances run against good and faulty NAND models.
module tb_nand_bist;

  localparam int N0 = 1000;
  localparam int P0 = 2;

  logic clk = 1'b0;
  logic reset;
  logic start;

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int t      = -1;
  bit trk    = 1'b0;
  int dt0    = 0;
  int dt3    = 0;

  logic [15:0] vec [0:N0-1];

  // u0: good model, defaults
  logic       r0, bs0, dn0;
  logic [7:0] a0, b0, o0;
  logic [15:0] p0, f0;
  // u1: out[3] stuck at 0
  logic       r1, bs1, dn1;
  logic [7:0] a1, b1, o1;
  logic [15:0] p1, f1;
  // u2: 2-cycle model, checker LATENCY=1
  logic       r2, bs2, dn2;
  logic [7:0] a2, b2, o2, q2;
  logic [15:0] p2, f2;
  // u3: 2-cycle model, checker LATENCY=2
  logic       r3, bs3, dn3;
  logic [7:0] a3, b3, o3, q3;
  logic [15:0] p3, f3;
  // u4: always wrong, 4-bit counters
  logic       r4, bs4, dn4;
  logic [7:0] a4, b4, o4;
  logic [3:0] p4, f4;

  always @(posedge clk) begin
    o0 <= !r0 ? 8'h00 : ~(a0 & b0);
    o1 <= !r1 ? 8'h00 : (~(a1 & b1) & 8'hF7);
    q2 <= !r2 ? 8'h00 : ~(a2 & b2);
    o2 <= !r2 ? 8'h00 : q2;
    q3 <= !r3 ? 8'h00 : ~(a3 & b3);
    o3 <= !r3 ? 8'h00 : q3;
    o4 <= !r4 ? 8'h00 : (a4 & b4);
  end

  nand_bist u0 (
    .clk(clk), .reset(reset), .start(start),
    .dut_out(o0), .dut_rst_n(r0), .a(a0), .b(b0),
    .busy(bs0), .done(dn0),
    .pass_cnt(p0), .fail_cnt(f0));

  nand_bist #(.NUM_VECTORS(16)) u1 (
    .clk(clk), .reset(reset), .start(start),
    .dut_out(o1), .dut_rst_n(r1), .a(a1), .b(b1),
    .busy(bs1), .done(dn1),
    .pass_cnt(p1), .fail_cnt(f1));

  nand_bist #(.NUM_VECTORS(16)) u2 (
    .clk(clk), .reset(reset), .start(start),
    .dut_out(o2), .dut_rst_n(r2), .a(a2), .b(b2),
    .busy(bs2), .done(dn2),
    .pass_cnt(p2), .fail_cnt(f2));

  nand_bist #(.NUM_VECTORS(16), .LATENCY(2)) u3 (
    .clk(clk), .reset(reset), .start(start),
    .dut_out(o3), .dut_rst_n(r3), .a(a3), .b(b3),
    .busy(bs3), .done(dn3),
    .pass_cnt(p3), .fail_cnt(f3));

  nand_bist #(.NUM_VECTORS(20), .CNT_W(4)) u4 (
    .clk(clk), .reset(reset), .start(start),
    .dut_out(o4), .dut_rst_n(r4), .a(a4), .b(b4),
    .busy(bs4), .done(dn4),
    .pass_cnt(p4), .fail_cnt(f4));

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic wait_t(input int tg);
    int n;
    n = 0;
    while (t < tg && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (t < tg) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: t=%0d expected %0d",
               t, tg);
    end
  endtask

  task automatic chk_rst0(input string nm);
    chk({nm, "_a"},    32'(a0),  0);
    chk({nm, "_b"},    32'(b0),  0);
    chk({nm, "_rstn"}, 32'(r0),  0);
    chk({nm, "_busy"}, 32'(bs0), 0);
    chk({nm, "_done"}, 32'(dn0), 0);
    chk({nm, "_pass"}, 32'(p0),  0);
    chk({nm, "_fail"}, 32'(f0),  0);
  endtask

  // Timeline model of u0: t counts edges since start was sampled
  always begin
    @(posedge clk);
    #1;
    if (trk) begin
      int k;
      t++;
      if (dn0 && dt0 == 0) dt0 = t;
      if (dn3 && dt3 == 0) dt3 = t;
      if (t < 2) begin
        chk("m_rstn", 32'(r0),  0);
        chk("m_busy", 32'(bs0), 1);
        chk("m_done", 32'(dn0), 0);
        chk("m_pass", 32'(p0),  0);
        chk("m_fail", 32'(f0),  0);
      end else begin
        k = (t - 2) / P0;
        if (k >= N0) k = N0;
        chk("m_rstn", 32'(r0),  1);
        chk("m_busy", 32'(k < N0), 32'(bs0));
        chk("m_done", 32'(dn0), 32'(k >= N0));
        chk("m_pass", 32'(p0),  32'(k));
        chk("m_fail", 32'(f0),  0);
        if (k >= N0) k = N0 - 1;
        chk("m_a", 32'(a0), 32'(vec[k][7:0]));
        chk("m_b", 32'(b0), 32'(vec[k][15:8]));
      end
    end
  end

  initial begin
    int nf1;
    vec[0] = 16'hACE1;
    for (int i = 1; i < N0; i++)
      vec[i] = (vec[i-1] >> 1) ^
               (vec[i-1][0] ? 16'hB400 : 16'h0);
    nf1 = 0;
    for (int i = 0; i < 16; i++)
      if (!(vec[i][3] && vec[i][11])) nf1++;

    chk("model_v1", 32'(vec[1]), 32'h0000E270);
    chk("model_v2", 32'(vec[2]), 32'h00007138);

    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk_rst0("por");
    reset = 1'b1;
    @(negedge clk);
    chk("idle_rstn", 32'(r0),  1);
    chk("idle_busy", 32'(bs0), 0);

    // Run 1
    start = 1'b1;
    t     = -1;
    trk   = 1'b1;
    @(negedge clk);
    start = 1'b0;

    wait_t(4);
    chk("v1_a", 32'(a0), 32'h70);
    chk("v1_b", 32'(b0), 32'hE2);

    // start while busy must be ignored
    wait_t(98);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    wait_t(2 + N0 * P0 + 1);
    chk("u0_done_t", 32'(dt0), 32'(2 + N0 * P0));
    chk("u0_pass",   32'(p0),  32'(N0));
    chk("u0_fail",   32'(f0),  0);
    chk("u1_pass",   32'(p1),  32'(16 - nf1));
    chk("u1_fail",   32'(f1),  32'(nf1));
    chk("u1_done",   32'(dn1), 1);
    chk("u2_fail_nz", 32'(f2 != 0), 1);
    chk("u2_sum",    32'(p2 + f2), 16);
    chk("u3_pass",   32'(p3),  16);
    chk("u3_fail",   32'(f3),  0);
    chk("u3_done_t", 32'(dt3), 32'(2 + 3 * 16));
    chk("u4_fail",   32'(f4),  15);
    chk("u4_pass",   32'(p4),  0);

    // Run 2: start from DONE, then reset at vector 5
    start = 1'b1;
    t     = -1;
    @(negedge clk);
    start = 1'b0;
    wait_t(13);
    trk   = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_rst0("mid");
    reset = 1'b1;

    // Run 3: must reproduce the seed sequence
    @(negedge clk);
    start = 1'b1;
    t     = -1;
    trk   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_t(2);
    chk("r3_a0", 32'(a0), 32'hE1);
    chk("r3_b0", 32'(b0), 32'hAC);
    wait_t(2 + N0 * P0 + 1);
    trk = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
